// File: rtl/weight_fetch_pkg.sv
// Shared types and default sizing for the weight fetch controller.
package weight_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } fetch_state_e;

  localparam int DEF_NUM_LANE = 2;
  localparam int DEF_TILE     = 6;
  localparam int DEF_WEIGHT_W = 12;
  localparam int DEF_DATA_W   = 512;
  localparam int DEF_ADDR_W   = 8;

  // Packed width of one TILE x TILE tile of WEIGHT_W elements.
  localparam int DEF_TILE_BITS = DEF_TILE * DEF_TILE * DEF_WEIGHT_W;

endpackage

// File: rtl/weight_fetch_controller_unpack.sv
// Slices one SRAM word into a row-major TILE x TILE tile; bits above the tile are dropped.
module weight_tile_unpack
  import weight_fetch_pkg::*;
#(
  parameter int TILE     = DEF_TILE,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]              word,
  output logic [TILE*TILE*WEIGHT_W-1:0]  tile
);

  localparam int TILE_BITS = TILE * TILE * WEIGHT_W;

  for (genvar i = 0; i < TILE; i++) begin : g_row
    for (genvar j = 0; j < TILE; j++) begin : g_col
      assign tile[(i*TILE+j)*WEIGHT_W +: WEIGHT_W] = word[(i*TILE+j)*WEIGHT_W +: WEIGHT_W];
    end
  end

  if (DATA_W > TILE_BITS) begin : g_spare
    logic unused_hi;
    assign unused_hi = ^word[DATA_W-1:TILE_BITS];
  end

endmodule

// File: rtl/weight_fetch_controller.sv
// Walks a run of input-depth indices, reads one weight word per lane per index,
// and presents the unpacked tiles under a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a job, ready_o high
// ISSUE | one-cycle read strobe on enabled lanes
// WAIT  | collecting per-lane read data
// OUT   | beat valid, held until ready_i
module weight_fetch_controller
  import weight_fetch_pkg::*;
#(
  parameter int NUM_LANE = DEF_NUM_LANE,
  parameter int TILE     = DEF_TILE,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDR_W-1:0]                     total_od_i,
  input  logic                                  start_i,
  input  logic [ADDR_W-1:0]                     od_base_i,
  input  logic [ADDR_W-1:0]                     id_start_i,
  input  logic [ADDR_W-1:0]                     id_count_i,
  output logic                                  ready_o,
  output logic [NUM_LANE-1:0]                   rd_en_o,
  output logic [NUM_LANE*ADDR_W-1:0]            rd_addr_o,
  input  logic [NUM_LANE*DATA_W-1:0]            rd_data_i,
  input  logic [NUM_LANE-1:0]                   rd_valid_i,
  output logic [NUM_LANE*TILE*TILE*WEIGHT_W-1:0] tile_o,
  output logic [NUM_LANE-1:0]                   lane_valid_o,
  output logic [NUM_LANE*ADDR_W-1:0]            od_o,
  output logic [ADDR_W-1:0]                     id_o,
  output logic                                  valid_o,
  output logic                                  last_o,
  input  logic                                  ready_i,
  output logic                                  busy_o,
  output logic                                  done_o
);

  localparam int TILE_BITS = TILE * TILE * WEIGHT_W;

  if (TILE_BITS > DATA_W) begin : g_bad_cfg
    $error("weight_fetch_controller: TILE*TILE*WEIGHT_W exceeds DATA_W");
  end

  fetch_state_e                  state;
  logic [ADDR_W-1:0]             od_base_q;
  logic [ADDR_W-1:0]             total_od_q;
  logic [ADDR_W-1:0]             id_q;
  logic [ADDR_W-1:0]             remaining_q;
  logic [NUM_LANE-1:0]           lane_en_q;
  logic [NUM_LANE-1:0]           captured_q;
  logic [NUM_LANE*TILE_BITS-1:0] tile_q;
  logic                          empty_done_q;

  logic [NUM_LANE*TILE_BITS-1:0] tile_unpacked;
  logic [ADDR_W-1:0]             ld_base;
  logic [ADDR_W-1:0]             ld_total;
  logic [ADDR_W-1:0]             ld_id;
  logic [ADDR_W-1:0]             ld_row;
  logic [NUM_LANE-1:0]           ld_en;
  logic [NUM_LANE*ADDR_W-1:0]    ld_addr;
  logic [NUM_LANE-1:0]           cap_now;
  logic [NUM_LANE-1:0]           captured_nxt;
  logic                          last_beat;

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    weight_tile_unpack #(
      .TILE     (TILE),
      .WEIGHT_W (WEIGHT_W),
      .DATA_W   (DATA_W)
    ) u_unpack (
      .word (rd_data_i[k*DATA_W +: DATA_W]),
      .tile (tile_unpacked[k*TILE_BITS +: TILE_BITS])
    );
  end

  // Operands of the next ISSUE: the job inputs on accept, the latched job on a beat advance.
  always_comb begin
    ld_en   = '0;
    ld_addr = '0;
    if (state == ST_IDLE) begin
      ld_base  = od_base_i;
      ld_total = total_od_i;
      ld_id    = id_start_i;
    end else begin
      ld_base  = od_base_q;
      ld_total = total_od_q;
      ld_id    = id_q + ADDR_W'(1);
    end
    ld_row = ld_total * ld_id;
    for (int k = 0; k < NUM_LANE; k++) begin
      ld_en[k] = ({1'b0, ld_base} + (ADDR_W+1)'(k)) < {1'b0, ld_total};
      if (ld_en[k])
        ld_addr[k*ADDR_W +: ADDR_W] = ld_base + ADDR_W'(k) + ld_row;
    end
  end

  always_comb begin
    last_beat    = (remaining_q == ADDR_W'(1));
    cap_now      = rd_valid_i & lane_en_q & ~captured_q & {NUM_LANE{state == ST_WAIT}};
    captured_nxt = captured_q | cap_now;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      od_base_q    <= '0;
      total_od_q   <= '0;
      id_q         <= '0;
      remaining_q  <= '0;
      lane_en_q    <= '0;
      captured_q   <= '0;
      tile_q       <= '0;
      empty_done_q <= 1'b0;
      rd_en_o      <= '0;
      rd_addr_o    <= '0;
    end else begin
      rd_en_o      <= '0;
      rd_addr_o    <= '0;
      empty_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            od_base_q   <= od_base_i;
            total_od_q  <= total_od_i;
            id_q        <= id_start_i;
            remaining_q <= id_count_i;
            if (id_count_i == '0) begin
              empty_done_q <= 1'b1;
            end else begin
              state      <= ST_ISSUE;
              lane_en_q  <= ld_en;
              captured_q <= '0;
              rd_en_o    <= ld_en;
              rd_addr_o  <= ld_addr;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          for (int k = 0; k < NUM_LANE; k++)
            if (cap_now[k])
              tile_q[k*TILE_BITS +: TILE_BITS] <= tile_unpacked[k*TILE_BITS +: TILE_BITS];
          captured_q <= captured_nxt;
          if (captured_nxt == lane_en_q)
            state <= ST_OUT;
        end
        ST_OUT: begin
          if (ready_i) begin
            remaining_q <= remaining_q - ADDR_W'(1);
            id_q        <= ld_id;
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              state      <= ST_ISSUE;
              lane_en_q  <= ld_en;
              captured_q <= '0;
              rd_en_o    <= ld_en;
              rd_addr_o  <= ld_addr;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o      = (state == ST_IDLE);
    busy_o       = (state != ST_IDLE);
    valid_o      = (state == ST_OUT);
    last_o       = valid_o && last_beat;
    done_o       = empty_done_q || (valid_o && ready_i && last_beat);
    id_o         = valid_o ? id_q : '0;
    lane_valid_o = valid_o ? lane_en_q : '0;
    od_o         = '0;
    tile_o       = '0;
    for (int k = 0; k < NUM_LANE; k++) begin
      if (valid_o)
        od_o[k*ADDR_W +: ADDR_W] = od_base_q + ADDR_W'(k);
      if (valid_o && lane_en_q[k])
        tile_o[k*TILE_BITS +: TILE_BITS] = tile_q[k*TILE_BITS +: TILE_BITS];
    end
  end

endmodule

// File: tb/tb_weight_fetch_controller.sv
// Randomized job/SRAM stimulus checked cycle by cycle against a job-level reference model.
module tb_weight_fetch_controller;
  import weight_fetch_pkg::*;

  localparam int NL = DEF_NUM_LANE;
  localparam int T  = DEF_TILE;
  localparam int WW = DEF_WEIGHT_W;
  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;
  localparam int TB = DEF_TILE_BITS;

  logic              clk;
  logic              reset;
  logic [AW-1:0]     total_od_i, od_base_i, id_start_i, id_count_i;
  logic              start_i, ready_o, valid_o, last_o, ready_i, busy_o, done_o;
  logic [NL-1:0]     rd_en_o, rd_valid_i, lane_valid_o;
  logic [NL*AW-1:0]  rd_addr_o, od_o;
  logic [NL*DW-1:0]  rd_data_i;
  logic [NL*TB-1:0]  tile_o;
  logic [AW-1:0]     id_o;

  weight_fetch_controller #(
    .NUM_LANE(NL), .TILE(T), .WEIGHT_W(WW), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .total_od_i(total_od_i), .start_i(start_i),
    .od_base_i(od_base_i), .id_start_i(id_start_i), .id_count_i(id_count_i),
    .ready_o(ready_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i), .tile_o(tile_o),
    .lane_valid_o(lane_valid_o), .od_o(od_o), .id_o(id_o), .valid_o(valid_o),
    .last_o(last_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] mem [256];

  // job-level model state
  int cyc = 0;
  bit job_active;
  int j_base, j_total, j_id0, j_cnt, beat;
  int issue_due, empty_due, last_deliv, out_age, ready_mode;
  bit in_out;
  logic [NL-1:0] exp_mask, delivered;
  int lat_cnt [NL];
  int lat_fix [NL];
  int lane_addr [NL];

  task automatic chk(input string tag, input logic [447:0] got, input logic [447:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int exp_addr(input int base, input int total, input int id, input int k);
    return (base + k + total * id) % 256;
  endfunction

  function automatic logic [NL-1:0] lane_mask(input int base, input int total);
    logic [NL-1:0] m;
    for (int k = 0; k < NL; k++) m[k] = (base + k) < total;
    return m;
  endfunction

  task automatic model_clear();
    job_active = 0; in_out = 0; out_age = 0; delivered = '0; exp_mask = '0;
    issue_due = -10; empty_due = -10; last_deliv = -10;
    for (int k = 0; k < NL; k++) lat_cnt[k] = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, ready_o, 1'b1);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_rd_en"}, rd_en_o, '0);
    chk({tag, "_rd_addr"}, rd_addr_o, '0);
    chk({tag, "_valid"}, valid_o, 1'b0);
    chk({tag, "_last"}, last_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_lane_valid"}, lane_valid_o, '0);
    chk({tag, "_od"}, od_o, '0);
    chk({tag, "_id"}, id_o, '0);
    for (int k = 0; k < NL; k++) chk($sformatf("%s_tile%0d", tag, k), tile_o[k*TB +: TB], '0);
  endtask

  // One clock: SRAM response, output checks, input drive, done check, model update.
  task automatic tick(input bit launch);
    logic [NL-1:0]    en_exp;
    logic [NL*AW-1:0] addr_exp;
    logic             vexp, dexp;
    bit               hs;
    int               bid;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NL; k++) begin
      rd_valid_i[k] = 1'b0;
      rd_data_i[k*DW +: DW] = rand_word();
      if (lat_cnt[k] > 0) begin
        lat_cnt[k]--;
        if (lat_cnt[k] == 0) begin
          rd_valid_i[k] = 1'b1;
          rd_data_i[k*DW +: DW] = mem[lane_addr[k]];
          delivered[k] = 1'b1;
          last_deliv = cyc;
        end
      end else if ((!job_active || !exp_mask[k] || delivered[k]) && $urandom_range(3) == 0) begin
        rd_valid_i[k] = 1'b1;
      end
    end

    chk("ready", ready_o, !job_active);
    chk("busy", busy_o, job_active);
    bid = (j_id0 + beat) % 256;
    en_exp = '0;
    addr_exp = '0;
    if (job_active && cyc == issue_due)
      for (int k = 0; k < NL; k++)
        if (exp_mask[k]) begin
          en_exp[k] = 1'b1;
          addr_exp[k*AW +: AW] = AW'(exp_addr(j_base, j_total, bid, k));
          lat_cnt[k] = (lat_fix[k] > 0) ? lat_fix[k] : int'($urandom_range(1, 4));
          lane_addr[k] = exp_addr(j_base, j_total, bid, k);
        end
    chk("rd_en", rd_en_o, en_exp);
    chk("rd_addr", rd_addr_o, addr_exp);

    vexp = 1'b0;
    if (job_active) begin
      if (in_out) vexp = 1'b1;
      else if (exp_mask != '0) vexp = (delivered == exp_mask) && (cyc >= last_deliv + 1);
      else vexp = (cyc >= issue_due + 2);
    end
    chk("valid", valid_o, vexp);
    if (valid_o && job_active) begin
      chk("lane_valid", lane_valid_o, exp_mask);
      chk("id", id_o, bid);
      chk("last", last_o, beat == j_cnt - 1);
      for (int k = 0; k < NL; k++) begin
        chk($sformatf("od%0d", k), od_o[k*AW +: AW], (j_base + k) % 256);
        chk($sformatf("tile%0d", k), tile_o[k*TB +: TB],
            exp_mask[k] ? mem[exp_addr(j_base, j_total, bid, k)][TB-1:0] : {TB{1'b0}});
      end
      in_out = 1;
      out_age++;
    end

    case (ready_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = ($urandom_range(2) != 0);
      default: ready_i = in_out && (out_age >= 5);
    endcase
    start_i = 1'b0;
    if (launch) begin
      start_i = 1'b1;
      od_base_i = AW'(j_base); total_od_i = AW'(j_total);
      id_start_i = AW'(j_id0); id_count_i = AW'(j_cnt);
    end else if (job_active && $urandom_range(2) == 0) begin
      start_i = 1'b1;
      od_base_i = AW'($urandom); total_od_i = AW'($urandom);
      id_start_i = AW'($urandom); id_count_i = AW'($urandom);
    end
    #1;
    hs = job_active && valid_o && ready_i;
    dexp = (cyc == empty_due) || (hs && beat == j_cnt - 1);
    chk("done", done_o, dexp);

    if (hs) begin
      beat++; in_out = 0; out_age = 0; delivered = '0;
      if (beat == j_cnt) job_active = 0;
      else issue_due = cyc + 1;
    end
    if (launch) begin
      if (j_cnt == 0) empty_due = cyc + 1;
      else begin
        job_active = 1; beat = 0; issue_due = cyc + 1;
        exp_mask = lane_mask(j_base, j_total); delivered = '0; in_out = 0; out_age = 0;
      end
    end
  endtask

  task automatic run_job(input int base, input int total, input int id0, input int cnt,
                         input int l0, input int l1, input int mode);
    int guard;
    j_base = base; j_total = total; j_id0 = id0; j_cnt = cnt;
    lat_fix[0] = l0; lat_fix[1] = l1; ready_mode = mode;
    tick(1);
    guard = 0;
    while (job_active && guard < 30 * cnt + 20) begin
      tick(0);
      guard++;
    end
    chk("job_timeout", job_active, 1'b0);
    if (job_active) begin
      @(negedge clk); reset = 1'b0; model_clear();
      @(negedge clk); reset = 1'b1;
    end
    tick(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start_i = 1'b0; ready_i = 1'b0; rd_valid_i = '0; rd_data_i = '0;
    total_od_i = '0; od_base_i = '0; id_start_i = '0; id_count_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    model_clear();
    j_base = 0; j_total = 0; j_id0 = 0; j_cnt = 0; beat = 0; ready_mode = 0;
    lat_fix[0] = 0; lat_fix[1] = 0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk); reset = 1'b1;

    // basic job: words at 4 and 5, element [0][0] = -3 and [5][5] = 7 on lane 0
    mem[4][0 +: WW]          = 12'hFFD;
    mem[4][(5*T+5)*WW +: WW] = 12'd7;
    run_job(0, 4, 1, 1, 1, 1, 0);
    run_job(4, 5, 1, 2, 1, 1, 0);   // lane 1 beyond depth, addresses 9 then 14
    run_job(0, 4, 2, 2, 1, 1, 2);   // 4 cycles of backpressure per beat
    run_job(2, 8, 3, 1, 1, 3, 0);   // skewed per-lane latency
    run_job(0, 4, 0, 0, 1, 1, 0);   // empty job
    run_job(1, 3, 254, 4, 2, 2, 1); // id wraps past 255
    run_job(9, 5, 0, 2, 1, 1, 0);   // no lane enabled

    // reset while waiting for read data
    j_base = 0; j_total = 4; j_id0 = 0; j_cnt = 2; lat_fix[0] = 6; lat_fix[1] = 6; ready_mode = 0;
    tick(1);
    while (cyc < issue_due + 1) tick(0);
    @(negedge clk);
    cyc++;
    reset = 1'b0; start_i = 1'b0; rd_valid_i = '1; rd_data_i = {rand_word(), rand_word()};
    #1 chk_zero("rst_wait");
    model_clear();
    @(negedge clk);
    cyc++;
    reset = 1'b1;
    repeat (6) tick(0);

    repeat (40) begin
      int tot, base;
      tot = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 255));
      base = ($urandom_range(4) == 0 || tot == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, tot - 1));
      run_job(base, tot, int'($urandom_range(0, 255)), int'($urandom_range(0, 4)),
              0, 0, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
